// File: rtl/pio_pkg.sv
// Shared PIO definitions: FIFO join encodings, debug-flag bit positions and
// sizing helpers used by the FIFO pair and the top-level register decode.
package pio_pkg;

    typedef enum logic [1:0] {
        JOIN_NONE = 2'b00,
        JOIN_TX   = 2'b01,
        JOIN_RX   = 2'b10
    } join_e;

    localparam int unsigned FDBG_TX_OVER  = 0;
    localparam int unsigned FDBG_RX_UNDER = 1;
    localparam int unsigned FDBG_RX_STALL = 2;
    localparam int unsigned FDBG_TX_STALL = 3;
    localparam int unsigned FDBG_W        = 4;

    // Level width: must hold 0..2*depth inclusive.
    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(2 * depth) + 1;
    endfunction

    // The reserved encoding 2'b11 behaves like separate mode.
    function automatic join_e decode_join(input logic [1:0] raw);
        join_e j;
        case (raw)
            2'b01:   j = JOIN_TX;
            2'b10:   j = JOIN_RX;
            default: j = JOIN_NONE;
        endcase
        return j;
    endfunction

endpackage

// File: rtl/pio_fifo_ctrl.sv
// Pointer, level and full/empty control for one FIFO direction. Capacity,
// base offset and enable come from the join mode chosen by the parent.
module pio_fifo_ctrl
    import pio_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned LW    = level_w(DEPTH),
    localparam int unsigned PW    = LW - 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_clear,
    input  logic          i_en,
    input  logic [LW-1:0] i_cap,
    input  logic [PW-1:0] i_base,
    input  logic          i_push,
    input  logic          i_pull,
    output logic [PW-1:0] o_wr_idx_c,
    output logic [PW-1:0] o_rd_idx_c,
    output logic          o_push_ok_c,
    output logic          o_push_drop_c,
    output logic          o_pull_drop_c,
    output logic          o_full_c,
    output logic          o_empty_c,
    output logic [LW-1:0] o_level
);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [LW-1:0] w_level_nxt;
    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_pull_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr,
                                              input logic [LW-1:0] cap);
        return (LW'(ptr) == cap - LW'(1)) ? '0 : ptr + PW'(1);
    endfunction

    // A disabled direction reports both full and empty so every access bounces.
    always_comb begin
        w_full    = !i_en || (r_level == i_cap);
        w_empty   = !i_en || (r_level == '0);
        w_push_ok = i_push && !w_full  && !i_clear;
        w_pull_ok = i_pull && !w_empty && !i_clear;
        w_level_nxt = r_level;
        if (w_push_ok && !w_pull_ok) begin
            w_level_nxt = r_level + LW'(1);
        end else if (!w_push_ok && w_pull_ok) begin
            w_level_nxt = r_level - LW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr, i_cap);
            end
            if (w_pull_ok) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr, i_cap);
            end
            r_level <= w_level_nxt;
        end
    end

    assign o_wr_idx_c    = i_base + r_wr_ptr;
    assign o_rd_idx_c    = i_base + r_rd_ptr;
    assign o_push_ok_c   = w_push_ok;
    assign o_push_drop_c = i_push && w_full  && !i_clear;
    assign o_pull_drop_c = i_pull && w_empty && !i_clear;
    assign o_full_c      = w_full;
    assign o_empty_c     = w_empty;
    assign o_level       = r_level;

endmodule

// File: rtl/pio_fifo_pair.sv
// PIO per-state-machine TX/RX FIFO pair sharing one storage array, with
// runtime join of all storage to one direction and sticky debug flags.
module pio_fifo_pair
    import pio_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned LW    = level_w(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [1:0]        i_join,
    input  logic              i_clear,
    input  logic              i_sys_push,
    input  logic [WIDTH-1:0]  i_sys_din,
    input  logic              i_sys_pull,
    output logic [WIDTH-1:0]  o_sys_dout,
    input  logic              i_sm_pull,
    output logic [WIDTH-1:0]  o_sm_dout,
    input  logic              i_sm_push,
    input  logic [WIDTH-1:0]  i_sm_din,
    output logic              o_tx_full,
    output logic              o_tx_empty,
    output logic              o_rx_full,
    output logic              o_rx_empty,
    output logic [LW-1:0]     o_tx_level,
    output logic [LW-1:0]     o_rx_level,
    output logic [FDBG_W-1:0] o_flags,
    input  logic [FDBG_W-1:0] i_flag_clr
);

    localparam int unsigned   PW      = LW - 1;
    localparam logic [LW-1:0] CAP_ONE = LW'(DEPTH);
    localparam logic [LW-1:0] CAP_TWO = LW'(2 * DEPTH);
    localparam logic [PW-1:0] RX_BASE = PW'(DEPTH);

    join_e             r_mode;
    logic [WIDTH-1:0]  r_mem [2*DEPTH];
    logic [FDBG_W-1:0] r_flags;
    logic [FDBG_W-1:0] w_flag_set;

    logic          w_tx_en, w_rx_en;
    logic [LW-1:0] w_tx_cap, w_rx_cap;
    logic [PW-1:0] w_rx_base;
    logic [PW-1:0] w_tx_wr_idx, w_tx_rd_idx, w_rx_wr_idx, w_rx_rd_idx;
    logic          w_tx_push_ok, w_tx_push_drop, w_tx_pull_drop;
    logic          w_rx_push_ok, w_rx_push_drop, w_rx_pull_drop;
    logic          w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;

    // Mode is registered; software pairs every join change with a clear.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mode <= JOIN_NONE;
        end else begin
            r_mode <= decode_join(i_join);
        end
    end

    always_comb begin
        w_tx_en   = (r_mode != JOIN_RX);
        w_rx_en   = (r_mode != JOIN_TX);
        w_tx_cap  = (r_mode == JOIN_TX) ? CAP_TWO : CAP_ONE;
        w_rx_cap  = (r_mode == JOIN_RX) ? CAP_TWO : CAP_ONE;
        w_rx_base = (r_mode == JOIN_RX) ? '0 : RX_BASE;
    end

    pio_fifo_ctrl #(.DEPTH(DEPTH)) u_tx_ctrl (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_clear       (i_clear),
        .i_en          (w_tx_en),
        .i_cap         (w_tx_cap),
        .i_base        ('0),
        .i_push        (i_sys_push),
        .i_pull        (i_sm_pull),
        .o_wr_idx_c    (w_tx_wr_idx),
        .o_rd_idx_c    (w_tx_rd_idx),
        .o_push_ok_c   (w_tx_push_ok),
        .o_push_drop_c (w_tx_push_drop),
        .o_pull_drop_c (w_tx_pull_drop),
        .o_full_c      (w_tx_full),
        .o_empty_c     (w_tx_empty),
        .o_level       (o_tx_level)
    );

    pio_fifo_ctrl #(.DEPTH(DEPTH)) u_rx_ctrl (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_clear       (i_clear),
        .i_en          (w_rx_en),
        .i_cap         (w_rx_cap),
        .i_base        (w_rx_base),
        .i_push        (i_sm_push),
        .i_pull        (i_sys_pull),
        .o_wr_idx_c    (w_rx_wr_idx),
        .o_rd_idx_c    (w_rx_rd_idx),
        .o_push_ok_c   (w_rx_push_ok),
        .o_push_drop_c (w_rx_push_drop),
        .o_pull_drop_c (w_rx_pull_drop),
        .o_full_c      (w_rx_full),
        .o_empty_c     (w_rx_empty),
        .o_level       (o_rx_level)
    );

    // At most one direction owns any entry, so the two writes never collide.
    always_ff @(posedge i_clk) begin
        if (w_tx_push_ok) begin
            r_mem[w_tx_wr_idx] <= i_sys_din;
        end
        if (w_rx_push_ok) begin
            r_mem[w_rx_wr_idx] <= i_sm_din;
        end
    end

    always_comb begin
        w_flag_set                = '0;
        w_flag_set[FDBG_TX_OVER]  = w_tx_push_drop;
        w_flag_set[FDBG_RX_UNDER] = w_rx_pull_drop;
        w_flag_set[FDBG_RX_STALL] = w_rx_push_drop;
        w_flag_set[FDBG_TX_STALL] = w_tx_pull_drop;
    end

    // New events take priority over a same-cycle clear request.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_flags <= '0;
        end else begin
            r_flags <= (r_flags & ~i_flag_clr) | w_flag_set;
        end
    end

    assign o_sm_dout  = w_tx_empty ? '0 : r_mem[w_tx_rd_idx];
    assign o_sys_dout = w_rx_empty ? '0 : r_mem[w_rx_rd_idx];
    assign o_tx_full  = w_tx_full;
    assign o_tx_empty = w_tx_empty;
    assign o_rx_full  = w_rx_full;
    assign o_rx_empty = w_rx_empty;
    assign o_flags    = r_flags;

endmodule

// File: doc/pio_fifo_pair.md
Name: pio_fifo_pair

Overview:
- Per-state-machine TX/RX FIFO pair for the PIO block, replacing the fixed 4-deep fifo instances.
- Depth and data width are parametrised.
- Adds runtime FIFO join: all storage goes to TX or to RX, doubling that FIFO's depth.
- Adds sticky debug flags (TX overflow, RX underflow, RX stall, TX stall) that the system side can read and clear.
- The system bus pushes TX and pulls RX; the state machine pulls TX and pushes RX.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 4, entries per unjoined FIFO; power of two, at least 2. Joined capacity is 2*DEPTH.
- LW, $clog2(2*DEPTH)+1, level width; derived localparam, not overridable.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- join  input  2  00 = separate, 01 = join TX (RX disabled), 10 = join RX (TX disabled), 11 = treated as 00.
- clear  input  1  synchronous flush of both FIFOs; flags are kept.
- sys_push  input  1  system write to TX.
- sys_din  input  WIDTH  TX write data.
- sys_pull  input  1  system read from RX.
- sys_dout  output  WIDTH  RX head, show-ahead.
- sm_pull  input  1  state-machine read from TX.
- sm_dout  output  WIDTH  TX head, show-ahead.
- sm_push  input  1  state-machine write to RX.
- sm_din  input  WIDTH  RX write data.
- tx_full, tx_empty, rx_full, rx_empty  output  1  status flags.
- tx_level, rx_level  output  LW  occupancy.
- flags  output  4  sticky: [0] tx_over, [1] rx_under, [2] rx_stall, [3] tx_stall.
- flag_clr  input  4  write-1-to-clear, bit-aligned with flags.

Behaviour:
- Storage: one 2*DEPTH x WIDTH array, written synchronously.
  - Separate mode: TX uses entries 0..DEPTH-1, RX uses DEPTH..2*DEPTH-1.
  - Joined mode: the active FIFO uses all entries, capacity 2*DEPTH.
- Show-ahead: sm_dout / sys_dout always present the head entry combinationally. They read 0 when the FIFO is empty.
- Latency: a word pushed in cycle N is visible at dout, and counted in level/empty, from cycle N+1.
- Every accept/reject decision uses state from before the cycle:
  - Push when not full: accepted.
  - Push when full: dropped, data unchanged. Sets tx_over (TX) or rx_stall (RX).
  - Pull when not empty: head advances.
  - Pull when empty: ignored. Sets tx_stall (TX) or rx_under (RX).
  - Push and pull together, neither blocked: both happen, level unchanged.
  - Push and pull together when full: pull accepted, push dropped, flag set.
  - Push and pull together when empty: push accepted, pull ignored, flag set.
- Disabled FIFO (the non-joined side):
  - Level 0; empty=1 and full=1.
  - All pushes dropped and all pulls ignored, with the flags set as above.
- Pointers are LW-1 bits, wrap modulo the current capacity, and are offset by the base index in separate mode.
- full means level == capacity; empty means level == 0.
- Flags are set by events and cleared by flag_clr. If set and clear hit the same bit in the same cycle, set wins.
- clear: pointers and levels go to 0 the next cycle; flags are kept. Any push or pull in the same cycle is discarded and sets no flags.
- Changing join without pulsing clear is undefined. Software must pulse clear in the same cycle or the next cycle; the bench checks only that sequence.
- Reset values: levels 0, tx_empty=rx_empty=1, tx_full=rx_full=0, flags 0, both douts 0. Reset mid-operation discards all contents.

Decomposition:
- Shared package pio_pkg: JOIN_NONE/JOIN_TX/JOIN_RX encodings and FDBG_* flag bit indices, also used by the pio top's register decode.
- Sub-module pio_fifo_ctrl: pointer, level and full/empty logic for one direction. Inputs: capacity, base offset, enable. Instantiated twice.

Test Plan:
- Reset, then sys_push 0xA0..0xA3, then sm_pull x4 -> sm_dout sequence A0,A1,A2,A3; tx_full=1 after the 4th push; tx_level 4→0; tx_empty=1 at end.
- Full TX plus one extra sys_push 0xFF -> word dropped, flags[0]=1; flag_clr=0001 -> flags[0]=0 the next cycle.
- join=01 with clear, then 8 sys_push -> tx_level=8, tx_full only after the 8th; rx_empty=rx_full=1; an sm_push sets flags[2].
- join=10 with clear, sm_push 8 words, sys_pull 9 -> 8 words in order, then flags[1]=1; rx_level=0.
- TX at level 2, sys_push and sm_pull in the same cycle -> level stays 2, FIFO order preserved. Same on an empty FIFO -> level 1, flags[3]=1.
- Reset asserted with both FIFOs half full -> all levels 0, douts 0, flags 0 the next cycle.
